reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 147 ++++++++++++++
 tb/tb_reset_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: merges POR, watchdog, external and software resets into a held-off core reset and boot pulse.
// Optional boot watchdog under RSTSEQ_BOOT_TIMEOUT_EN re-enters reset when boot never reports done.
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_memAddr,
    input  logic [15:0] i_memDataIn,
    input  logic        i_memWrEn,
    output logic [15:0] o_memDataOut,
    input  logic        i_wdtReset,
    input  logic        i_extReset,
    input  logic        i_bootDone,
    output logic        o_sysRstn,
    output logic        o_bootStart
);

    localparam logic [1:0] ST_HOLD   = 2'd0;
    localparam logic [1:0] ST_BOOT   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sys_rstn_q, sys_rstn_d;
    logic       boot_start_q, boot_start_d;
    logic [4:0] cause_q, cause_d;
    logic [7:0] rst_cnt_q, rst_cnt_d;
    logic       sw_req;
    logic       tmo_evt;
    logic       any_evt;
    logic       wr_cause;
    logic       wr_rst_cnt;

    assign sw_req     = i_memWrEn && (i_memAddr == 2'b10) && (i_memDataIn == 16'h00A5);
    assign wr_cause   = i_memWrEn && (i_memAddr == 2'b00);
    assign wr_rst_cnt = i_memWrEn && (i_memAddr == 2'b01);

`ifdef RSTSEQ_BOOT_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;

    // Counter holds BOOT cycles already elapsed; the 65535th BOOT cycle fires the event.
    assign tmo_evt = (state_q == ST_BOOT) && !i_bootDone && (tmo_q == 16'hFFFE);

    always_comb begin
        tmo_d = '0;
        if (state_q == ST_BOOT) begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_evt = 1'b0;
`endif

    assign any_evt = i_rst || i_wdtReset || i_extReset || sw_req || tmo_evt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (any_evt) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_BOOT;
                    end
                end
                ST_BOOT: begin
                    if (i_bootDone) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            endcase
        end
        sys_rstn_d   = (state_d != ST_HOLD);
        boot_start_d = (state_d == ST_BOOT) && (state_q != ST_BOOT);
    end

    // Clear is applied before set so a source active in the write cycle keeps its bit.
    always_comb begin
        cause_d = cause_q;
        if (wr_cause) begin
            cause_d = cause_q & ~i_memDataIn[4:0];
        end
        cause_d = cause_d | {tmo_evt, i_extReset, sw_req, i_wdtReset, 1'b0};
    end

    always_comb begin
        rst_cnt_d = rst_cnt_q;
        if (wr_rst_cnt) begin
            rst_cnt_d = '0;
        end
        if (any_evt && (state_q != ST_HOLD) && (rst_cnt_d != 8'hFF)) begin
            rst_cnt_d = rst_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_HOLD;
            cnt_q        <= HOLD_LOAD;
            sys_rstn_q   <= 1'b0;
            boot_start_q <= 1'b0;
            cause_q      <= 5'b00001;
            rst_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sys_rstn_q   <= sys_rstn_d;
            boot_start_q <= boot_start_d;
            cause_q      <= cause_d;
            rst_cnt_q    <= rst_cnt_d;
        end
    end

    always_comb begin
        o_memDataOut = 16'h0000;
        case (i_memAddr)
            2'b00:   o_memDataOut = {11'b0, cause_q};
            2'b01:   o_memDataOut = {8'b0, rst_cnt_q};
            default: o_memDataOut = 16'h0000;
        endcase
    end

    assign o_sysRstn   = sys_rstn_q;
    assign o_bootStart = boot_start_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random traffic against a cycles-remaining reference model.
module tb_reset_sequencer;

    localparam int H = 16;

    logic        i_clk;
    logic        i_rst;
    logic [1:0]  i_memAddr;
    logic [15:0] i_memDataIn;
    logic        i_memWrEn;
    logic [15:0] o_memDataOut;
    logic        i_wdtReset;
    logic        i_extReset;
    logic        i_bootDone;
    logic        o_sysRstn;
    logic        o_bootStart;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: low-time remaining, boot/run phase flags, cause bits and reset tally.
    int         m_left  = H;
    bit         m_boot  = 0;
    bit         m_run   = 0;
    bit         m_bs    = 0;
    int         m_bcyc  = 0;
    logic [4:0] m_cause = 5'b00001;
    int         m_rc    = 0;

    reset_sequencer #(.HOLD_CYCLES(H)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_memAddr    (i_memAddr),
        .i_memDataIn  (i_memDataIn),
        .i_memWrEn    (i_memWrEn),
        .o_memDataOut (o_memDataOut),
        .i_wdtReset   (i_wdtReset),
        .i_extReset   (i_extReset),
        .i_bootDone   (i_bootDone),
        .o_sysRstn    (o_sysRstn),
        .o_bootStart  (o_bootStart)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_rd(input logic [1:0] addr);
        case (addr)
            2'b00:   return {11'b0, m_cause};
            2'b01:   return 16'(m_rc);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model(input logic rst, input logic wdt, input logic ext, input logic done,
                         input logic wr, input logic [1:0] addr, input logic [15:0] data);
        logic sw, tmo, evt, was_active;
        sw  = wr && (addr == 2'b10) && (data == 16'h00A5);
        tmo = 1'b0;
`ifdef RSTSEQ_BOOT_TIMEOUT_EN
        if (m_boot && !done && (m_bcyc + 1 == 65535)) tmo = 1'b1;
`endif
        evt        = rst || wdt || ext || sw || tmo;
        was_active = (m_left == 0);
        m_bs       = 0;
        if (evt) begin
            m_left = H;
            m_boot = 0;
            m_run  = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_boot = 1;
                m_bcyc = 0;
                m_bs   = 1;
            end
        end else if (m_boot) begin
            m_bcyc++;
            if (done) begin
                m_boot = 0;
                m_run  = 1;
            end
        end
        if (rst) begin
            m_cause = 5'b00001;
            m_rc    = 0;
        end else begin
            if (wr && addr == 2'b00) m_cause = m_cause & ~data[4:0];
            m_cause = m_cause | {tmo, ext, sw, wdt, 1'b0};
            if (wr && addr == 2'b01) m_rc = 0;
            if (evt && was_active) m_rc = (m_rc < 255) ? m_rc + 1 : 255;
        end
    endtask

    task automatic step(input logic rst, input logic wdt, input logic ext, input logic done,
                        input logic wr, input logic [1:0] addr, input logic [15:0] data);
        i_rst       = rst;
        i_wdtReset  = wdt;
        i_extReset  = ext;
        i_bootDone  = done;
        i_memWrEn   = wr;
        i_memAddr   = addr;
        i_memDataIn = data;
        @(posedge i_clk);
        model(rst, wdt, ext, done, wr, addr, data);
        #1;
        chk("sys_rstn", {15'b0, o_sysRstn}, {15'b0, (m_left == 0)});
        chk("boot_start", {15'b0, o_bootStart}, {15'b0, m_bs});
        chk("mem_read", o_memDataOut, exp_rd(addr));
    endtask

    task automatic idle(input int n, input logic [1:0] addr);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, addr, 16'h0000);
    endtask

    task automatic go_run();
        for (int i = 0; i < 300 && !m_run; i++) step(0, 0, 0, 1, 0, 2'b01, 16'h0000);
    endtask

    initial begin
        // Power-on reset held three cycles.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 2'b00, 16'h0000);
            chk("por_cause", o_memDataOut, 16'h0001);
            chk("por_rstn", {15'b0, o_sysRstn}, 16'h0000);
        end
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, 0, 0, 2'b01, 16'h0000);
            chk("por_hold_low", {15'b0, o_sysRstn}, 16'h0000);
            chk("por_rcnt", o_memDataOut, 16'h0000);
        end
        step(0, 0, 0, 0, 0, 2'b00, 16'h0000);
        chk("por_release", {15'b0, o_sysRstn}, 16'h0001);
        chk("por_boot_pulse", {15'b0, o_bootStart}, 16'h0001);
        chk("por_cause_after", o_memDataOut, 16'h0001);
        step(0, 0, 0, 1, 0, 2'b01, 16'h0000);
        chk("por_pulse_end", {15'b0, o_bootStart}, 16'h0000);

        // Watchdog reset from RUN, then write-1-to-clear.
        step(0, 1, 0, 0, 0, 2'b00, 16'h0000);
        chk("wdt_rstn", {15'b0, o_sysRstn}, 16'h0000);
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, 0, 0, 2'b00, 16'h0000);
            chk("wdt_hold_low", {15'b0, o_sysRstn}, 16'h0000);
        end
        step(0, 0, 0, 0, 0, 2'b00, 16'h0000);
        chk("wdt_release", {15'b0, o_sysRstn}, 16'h0001);
        step(0, 0, 0, 1, 0, 2'b00, 16'h0000);
        chk("wdt_cause", o_memDataOut, 16'h0003);
        step(0, 0, 0, 0, 0, 2'b01, 16'h0000);
        chk("wdt_rcnt", o_memDataOut, 16'h0001);
        step(0, 0, 0, 0, 1, 2'b00, 16'h0002);
        chk("w1c_cause", o_memDataOut, 16'h0001);

        // Software reset: wrong key ignored, right key resets.
        step(0, 0, 0, 0, 1, 2'b10, 16'h00A4);
        chk("sw_badkey_run", {15'b0, o_sysRstn}, 16'h0001);
        step(0, 0, 0, 0, 1, 2'b10, 16'h00A5);
        chk("sw_reset", {15'b0, o_sysRstn}, 16'h0000);
        step(0, 0, 0, 0, 0, 2'b00, 16'h0000);
        chk("sw_cause", o_memDataOut, 16'h0005);
        go_run();

        // External request while HOLD counter is 3 restarts the hold-off.
        step(0, 1, 0, 0, 0, 2'b01, 16'h0000);
        idle(13, 2'b01);
        chk("ext_pre_rcnt", o_memDataOut, 16'h0003);
        step(0, 0, 1, 0, 0, 2'b01, 16'h0000);
        chk("ext_rcnt_same", o_memDataOut, 16'h0003);
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, 0, 0, 2'b00, 16'h0000);
            chk("ext_hold_low", {15'b0, o_sysRstn}, 16'h0000);
        end
        step(0, 0, 0, 0, 0, 2'b00, 16'h0000);
        chk("ext_release", {15'b0, o_sysRstn}, 16'h0001);
        chk("ext_cause", o_memDataOut, 16'h000F);

        // Same-cycle set/clear collisions.
        step(0, 0, 0, 1, 0, 2'b00, 16'h0000);
        step(0, 0, 0, 0, 1, 2'b00, 16'hFFFF);
        chk("cause_clear_all", o_memDataOut, 16'h0000);
        step(0, 1, 0, 0, 1, 2'b00, 16'h0002);
        chk("cause_set_wins", o_memDataOut, 16'h0002);
        go_run();
        step(0, 1, 0, 0, 1, 2'b01, 16'h1234);
        chk("rcnt_inc_wins", o_memDataOut, 16'h0001);

        // Reset counter saturation.
        go_run();
        step(0, 0, 0, 0, 1, 2'b01, 16'h0000);
        chk("rcnt_clear", o_memDataOut, 16'h0000);
        for (int i = 0; i < 256; i++) begin
            go_run();
            step(0, 1, 0, 0, 0, 2'b01, 16'h0000);
        end
        step(0, 0, 0, 0, 0, 2'b01, 16'h0000);
        chk("rcnt_saturate", o_memDataOut, 16'h00FF);

`ifdef RSTSEQ_BOOT_TIMEOUT_EN
        idle(15, 2'b00);
        chk("tmo_in_boot", {15'b0, o_sysRstn}, 16'h0001);
        idle(65535, 2'b00);
        chk("tmo_reset", {15'b0, o_sysRstn}, 16'h0000);
        chk("tmo_cause", o_memDataOut & 16'h0010, 16'h0010);
`else
        idle(15, 2'b00);
        idle(400, 2'b00);
        chk("boot_waits", {15'b0, o_sysRstn}, 16'h0001);
        chk("no_tmo_cause", o_memDataOut & 16'h0010, 16'h0000);
`endif

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  a;
            logic [15:0] d;
            logic        w;
            a = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 5) == 0);
            d = 16'($urandom);
            if (a == 2'b10 && $urandom_range(0, 2) == 0) d = 16'h00A5;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, w, a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
